// File: rtl/panda_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then holds a registered response until the core takes it.
module panda_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_width_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a request transfers on a rising edge with req_valid_i & req_ready_o;
  // a response transfers on a rising edge with rsp_valid_o & rsp_ready_i, and the
  // response fields hold steady from the moment rsp_valid_o rises until that edge.

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the response forms on the accepting edge, so the
  // live request fields are used then; otherwise the captured copy is used.
  logic        accept;
  logic        enter_resp;
  logic        t_we;
  logic [31:0] t_addr;
  logic [1:0]  t_width;
  logic        t_unsigned;
  logic [31:0] t_wdata;
  logic        t_err;
  logic [AW-1:0] t_idx;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] wd_shift;
  logic        commit;

  assign accept = (state == S_IDLE) && ready_q && req_valid_i;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

  always_comb begin
    t_we       = we_q;
    t_addr     = addr_q;
    t_width    = width_q;
    t_unsigned = unsigned_q;
    t_wdata    = wdata_q;
    if (state == S_IDLE) begin
      t_we       = req_we_i;
      t_addr     = req_addr_i;
      t_width    = req_width_i;
      t_unsigned = req_unsigned_i;
      t_wdata    = req_wdata_i;
    end
  end

  always_comb begin
    t_err = 1'b0;
    if (t_width == 2'd3) t_err = 1'b1;
    if ((t_width == 2'd1) && t_addr[0]) t_err = 1'b1;
    if ((t_width == 2'd2) && (t_addr[1:0] != 2'd0)) t_err = 1'b1;
    if ({2'b00, t_addr[31:2]} >= DEPTH_LIM) t_err = 1'b1;
  end

  assign t_idx    = t_addr[AW+1:2];
  assign rd_word  = mem[t_idx];
  assign rd_shift = rd_word >> {t_addr[1:0], 3'b000};
  assign wd_shift = t_wdata << {t_addr[1:0], 3'b000};

  always_comb begin
    load_data = rd_shift;
    byte_en   = 4'b1111;
    case (t_width)
      2'd0: begin
        load_data = t_unsigned ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        byte_en   = 4'b0001 << t_addr[1:0];
      end
      2'd1: begin
        load_data = t_unsigned ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        byte_en   = t_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_data = rd_shift;
        byte_en   = 4'b1111;
      end
    endcase
  end

  assign commit = enter_resp && t_we && !t_err;

  // Array is deliberately left out of reset; a store lands only on the RESP-entry edge.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[t_idx][8*b +: 8] <= wd_shift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      width_q     <= 2'd0;
      unsigned_q  <= 1'b0;
      wdata_q     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (req_valid_i) begin
            ready_q    <= 1'b0;
            we_q       <= req_we_i;
            addr_q     <= req_addr_i;
            width_q    <= req_width_i;
            unsigned_q <= req_unsigned_i;
            wdata_q    <= req_wdata_i;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else cnt <= cnt - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state       <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= t_err;
        rsp_rdata_q <= (t_err || t_we) ? 32'd0 : load_data;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign dbg_state_o = state;

endmodule
